// File: rtl/seq_divider_pkg.sv
// rtl/seq_divider_pkg.sv - shared widths, FSM encoding and constants for the sequential divider
package seq_divider_pkg;

    localparam int DIV_WIDTH = 16;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH) + 1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD_DVS = 3'd1,
        ST_CHECK    = 3'd2,
        ST_ITER     = 3'd3,
        ST_FIX      = 3'd4,
        ST_DONE     = 3'd5
    } state_e;

    // Quotient reported for a zero divisor has every bit set
    localparam logic DBZ_QUOTIENT_BIT = 1'b1;
    localparam logic [DIV_WIDTH-1:0] DBZ_QUOTIENT = {DIV_WIDTH{DBZ_QUOTIENT_BIT}};

endpackage

// File: rtl/seq_divider_datapath.sv
// rtl/seq_divider_datapath.sv - restoring-division registers, subtractor, sign fix and counter (SEQ_DIVIDER_SIGNED_EN)
module seq_divider_datapath
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ld_dvd_i,
    input  logic             ld_dvs_i,
    input  logic             check_i,
    input  logic             iter_i,
    input  logic             fix_i,
    output logic             m_zero_o,
    output logic             cnt_last_o,
    output logic             div_by_zero_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o
);

    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] m_q, dvd_q;
    logic [WIDTH-1:0] quotient_q, remainder_q;
    logic [CNT_W-1:0] cnt_q;
    logic             qneg_q, rneg_q, dbz_q;

    logic             dvd_neg, dvs_neg;
    logic [WIDTH-1:0] dvd_mag, dvs_mag;
    logic [WIDTH+1:0] a_sh, trial;
    logic [WIDTH-1:0] quot_fix, rem_fix;

`ifdef SEQ_DIVIDER_SIGNED_EN
    assign dvd_neg = dvd_q[WIDTH-1];
    assign dvs_neg = m_q[WIDTH-1];
    assign dvd_mag = dvd_neg ? -dvd_q : dvd_q;
    assign dvs_mag = dvs_neg ? -m_q : m_q;
`else
    assign dvd_neg = 1'b0;
    assign dvs_neg = 1'b0;
    assign dvd_mag = dvd_q;
    assign dvs_mag = m_q;
`endif

    // Sign restoration; the negate flags are constant zero in the unsigned build
    assign quot_fix = qneg_q ? -q_q : q_q;
    assign rem_fix  = rneg_q ? -a_q[WIDTH-1:0] : a_q[WIDTH-1:0];

    // One restoring step: shift {A,Q}, trial-subtract M, keep the difference when non-negative
    always_comb begin
        a_sh  = {a_q, q_q[WIDTH-1]};
        trial = a_sh - {2'b00, m_q};
        a_d   = a_sh[WIDTH:0];
        q_d   = {q_q[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH+1]) begin
            a_d    = trial[WIDTH:0];
            q_d[0] = 1'b1;
        end
    end

    // Datapath registers, each loaded only by its control strobe
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_q         <= '0;
            q_q         <= '0;
            m_q         <= '0;
            dvd_q       <= '0;
            cnt_q       <= '0;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
            dbz_q       <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            if (ld_dvd_i) begin
                dvd_q <= data_i;
                dbz_q <= 1'b0;
            end
            if (ld_dvs_i) begin
                m_q <= data_i;
            end
            if (check_i) begin
                if (m_q == '0) begin
                    quotient_q  <= {WIDTH{DBZ_QUOTIENT_BIT}};
                    remainder_q <= dvd_q;
                    dbz_q       <= 1'b1;
                end else begin
                    a_q    <= '0;
                    q_q    <= dvd_mag;
                    m_q    <= dvs_mag;
                    cnt_q  <= CNT_W'(WIDTH);
                    qneg_q <= dvd_neg ^ dvs_neg;
                    rneg_q <= dvd_neg;
                end
            end
            if (iter_i) begin
                a_q   <= a_d;
                q_q   <= q_d;
                cnt_q <= cnt_q - CNT_W'(1);
            end
            // A zero divisor already loaded its results in CHECK
            if (fix_i && !dbz_q) begin
                quotient_q  <= quot_fix;
                remainder_q <= rem_fix;
            end
        end
    end

    assign m_zero_o      = (m_q == '0);
    assign cnt_last_o    = (cnt_q == CNT_W'(1));
    assign div_by_zero_o = dbz_q;
    assign quotient_o    = quotient_q;
    assign remainder_o   = remainder_q;

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - sequential restoring divider top with control FSM (SEQ_DIVIDER_SIGNED_EN selects signed mode)
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    state_e state_q;
    logic   busy_q, done_q;
    logic   m_zero, cnt_last;

    // Control FSM; a zero divisor also leaves through FIX so both paths exit from one state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_LOAD_DVS;
                        busy_q  <= 1'b1;
                    end
                end
                ST_LOAD_DVS: state_q <= ST_CHECK;
                ST_CHECK:    state_q <= m_zero ? ST_FIX : ST_ITER;
                ST_ITER: begin
                    if (cnt_last) begin
                        state_q <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    state_q <= ST_DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                ST_DONE:     state_q <= ST_IDLE;
                default:     state_q <= ST_IDLE;
            endcase
        end
    end

    seq_divider_datapath #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_datapath (
        .clk_i         (clk),
        .rst_i         (rst),
        .data_i        (data_in),
        .ld_dvd_i      ((state_q == ST_IDLE) && start),
        .ld_dvs_i      (state_q == ST_LOAD_DVS),
        .check_i       (state_q == ST_CHECK),
        .iter_i        (state_q == ST_ITER),
        .fix_i         (state_q == ST_FIX),
        .m_zero_o      (m_zero),
        .cnt_last_o    (cnt_last),
        .div_by_zero_o (div_by_zero),
        .quotient_o    (quotient),
        .remainder_o   (remainder)
    );

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - scoreboard bench for seq_divider (SEQ_DIVIDER_SIGNED_EN selects signed cases)
module tb_seq_divider;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] data_in;
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .data_in     (data_in),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .quotient    (quotient),
        .remainder   (remainder)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [W-1:0] q, input logic [W-1:0] r, input logic dbz);
        exp_t e;
        e.q = q; e.r = r; e.dbz = dbz;
        return e;
    endfunction

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int x, y, qq, rr;
        if (b == '0) return mk('1, a, 1'b1);
`ifdef SEQ_DIVIDER_SIGNED_EN
        x = int'($signed(a));
        y = int'($signed(b));
`else
        x = int'(a);
        y = int'(b);
`endif
        qq = x / y;
        rr = x % y;
        e.q = qq[W-1:0];
        e.r = rr[W-1:0];
        e.dbz = 1'b0;
        return e;
    endfunction

    // mode: 0 start low after capture, 1 start held high, 2 random start pulses mid-op
    task automatic run_op(input logic [W-1:0] dvd, input logic [W-1:0] dvs, input exp_t e, input int mode);
        exp_t got;
        int   edge_n;
        int   lat;
        bit   seen;
        lat = e.dbz ? 3 : 19;
        sb.push_back(e);
        start = 1'b1; data_in = dvd;
        @(posedge clk); #1;
        data_in = dvs;
        start = (mode != 0);
        @(posedge clk); #1;
        data_in = W'($urandom);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++; $display("FAIL busy_after_load: got %b want 1", busy);
        end
        edge_n = 1; seen = 1'b0;
        while (!seen && edge_n < 60) begin
            start = (mode == 1) ? 1'b1 : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk); #1;
            edge_n++;
            if (done === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (!seen || edge_n != lat) begin
            n_bad++; $display("FAIL latency %0d/%0d: done after edge %0d (seen=%0b) want %0d", dvd, dvs, edge_n, seen, lat);
        end
        if (sb.size() == 0) begin
            n_cmp++; n_bad++; $display("FAIL scoreboard_empty: got empty want 1 entry");
        end else begin
            got = sb.pop_front();
            if (seen) begin
                n_cmp++;
                if (quotient !== got.q) begin
                    n_bad++; $display("FAIL quotient %h/%h: got %h want %h", dvd, dvs, quotient, got.q);
                end
                n_cmp++;
                if (remainder !== got.r) begin
                    n_bad++; $display("FAIL remainder %h/%h: got %h want %h", dvd, dvs, remainder, got.r);
                end
                n_cmp++;
                if (div_by_zero !== got.dbz || busy !== 1'b0) begin
                    n_bad++; $display("FAIL flags_at_done %h/%h: got dbz=%b busy=%b want dbz=%b busy=0", dvd, dvs, div_by_zero, busy, got.dbz);
                end
            end
        end
        start = (mode != 0);
        @(posedge clk); #1;
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0 || div_by_zero !== e.dbz) begin
            n_bad++; $display("FAIL after_done: got done=%b busy=%b dbz=%b want done=0 busy=0 dbz=%b", done, busy, div_by_zero, e.dbz);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
            n_bad++; $display("FAIL reset_state: got busy=%b done=%b dbz=%b q=%h r=%h want all 0", busy, done, div_by_zero, quotient, remainder);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned();
        run_op(16'd45, 16'd7, mk(16'd6, 16'd3, 1'b0), 0);
        run_op(16'hFFFF, 16'd1, mk(16'hFFFF, 16'd0, 1'b0), 0);
        run_op(16'd3, 16'd10, mk(16'd0, 16'd3, 1'b0), 0);
`ifndef SEQ_DIVIDER_SIGNED_EN
        run_op(16'hFFB2, 16'd5, mk(16'h3323, 16'd3, 1'b0), 0);
`endif
    endtask

    task automatic test_signed();
`ifdef SEQ_DIVIDER_SIGNED_EN
        run_op(16'hFFB2, 16'd5, mk(16'hFFF1, 16'hFFFD, 1'b0), 0);
        run_op(16'h8000, 16'hFFFF, mk(16'h8000, 16'h0000, 1'b0), 0);
        run_op(16'd7, 16'hFFFE, mk(16'hFFFD, 16'h0001, 1'b0), 0);
`endif
    endtask

    task automatic test_div_by_zero();
        run_op(16'd100, 16'd0, mk(16'hFFFF, 16'd100, 1'b1), 0);
    endtask

    task automatic test_reset_mid_op();
        bit saw;
        start = 1'b1; data_in = 16'd45;
        @(posedge clk); #1;
        start = 1'b0; data_in = 16'd7;
        repeat (9) begin
            @(posedge clk); #1;
        end
        #3 rst = 1'b1;
        #1;
        n_cmp++;
        if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
            n_bad++; $display("FAIL async_reset_clear: got busy=%b done=%b dbz=%b q=%h r=%h want all 0", busy, done, div_by_zero, quotient, remainder);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        saw = 1'b0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) saw = 1'b1;
        end
        n_cmp++;
        if (saw) begin
            n_bad++; $display("FAIL aborted_op_activity: got done/busy=1 want 0");
        end
        run_op(16'd1000, 16'd33, mk(16'd30, 16'd10, 1'b0), 0);
    endtask

    task automatic test_back_to_back();
        run_op(16'd45, 16'd7, mk(16'd6, 16'd3, 1'b0), 1);
        run_op(16'd1000, 16'd33, mk(16'd30, 16'd10, 1'b0), 1);
        run_op(16'd100, 16'd0, mk(16'hFFFF, 16'd100, 1'b1), 1);
        run_op(16'd3, 16'd10, mk(16'd0, 16'd3, 1'b0), 1);
        run_op(16'd500, 16'd9, model(16'd500, 16'd9), 2);
    endtask

    task automatic test_random();
        logic [W-1:0] a, b;
        for (int i = 0; i < 8; i++) begin
            a = W'($urandom);
            b = ($urandom_range(0, 2) == 0) ? W'($urandom_range(0, 20)) : W'($urandom);
            run_op(a, b, model(a, b), i % 3);
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_by_zero();
        test_reset_mid_op();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
